load_store_unit: RTL

Multicycle data-memory access unit on the execute/memory boundary of the RV32I core. It accepts one load or store per request, qualified by the MemWrite and funct3 fields the main decoder produces. It drives a word-addressed memory port with byte enables and waits for a memory acknowledge. It returns sign- or zero-extended load data, or flags a misaligned or illegal access without touching memory.

---
 rtl/load_store_unit_if.sv | 41 ++++
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the load/store unit's core-side request/response handshake and its
// word-addressed memory port.
//   req_valid/req_ready, mem_write, funct3, addr, wdata : request from the core
//   resp_valid, rdata, misaligned                       : completion to the core
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata        : request to memory
//   mem_ack, mem_rdata                                  : completion from memory
// slave  : the view taken by load_store_unit.
// master : the view taken by its environment (core + memory).
interface load_store_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   rdata;
  logic              misaligned;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, mem_write, funct3, addr, wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, rdata, misaligned,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, mem_write, funct3, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, rdata, misaligned,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle RV32I data-memory access unit. Accepts one load/store in IDLE,
// issues a single word-addressed memory access with byte enables, waits for
// mem_ack, then returns extended load data (or flags an illegal/misaligned
// access without touching memory) with a one-cycle resp_valid pulse.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (request, response and memory port)
// All outputs are registered; memory outputs come only from captured fields.
module load_store_unit (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misaligned_q, misaligned_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;

  logic              legal_c;
  logic [BE_W-1:0]   be_c;
  logic [XLEN-1:0]   lane_wdata_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [XLEN-1:0]   load_data_c;

  // Legality of the incoming request: size/sign encoding and natural alignment.
  always_comb begin
    legal_c = 1'b0;
    unique case (bus.funct3)
      3'b000:         legal_c = 1'b1;
      3'b001:         legal_c = ~bus.addr[0];
      3'b010:         legal_c = (bus.addr[1:0] == 2'b00);
      3'b100:         legal_c = ~bus.mem_write;
      3'b101:         legal_c = ~bus.mem_write & ~bus.addr[0];
      default:        legal_c = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_c         = 4'b1111;
    lane_wdata_c = '0;
    if (bus.mem_write) begin
      unique case (bus.funct3[1:0])
        2'b00: begin
          be_c         = 4'b0001 << bus.addr[1:0];
          lane_wdata_c = {4{bus.wdata[7:0]}};
        end
        2'b01: begin
          be_c         = bus.addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata_c = {2{bus.wdata[15:0]}};
        end
        default: begin
          be_c         = 4'b1111;
          lane_wdata_c = bus.wdata;
        end
      endcase
    end
  end

  // Lane extraction and sign/zero extension of the returned memory word.
  always_comb begin
    byte_c = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_c = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_data_c = {24'h000000, byte_c};
      3'b101:  load_data_c = {16'h0000, half_c};
      default: load_data_c = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    mem_req_d    = 1'b0;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          req_ready_d = 1'b0;
          funct3_d    = bus.funct3;
          off_d       = bus.addr[1:0];
          if (legal_c) begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.mem_write;
            mem_addr_d  = {bus.addr[XLEN-1:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = lane_wdata_c;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            misaligned_d = 1'b1;
            rdata_d      = '0;
          end
        end
      end
      ACCESS: begin
        mem_req_d = 1'b1;
        if (bus.mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          misaligned_d = 1'b0;
          rdata_d      = mem_we_q ? '0 : load_data_c;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.misaligned = misaligned_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
